// File: rtl/pcfx_bkram_pkg.sv
// Shared types and constants for the PC-FX backup-RAM image controller.
// Slot 1 (FX-BMP) is built only when PCFX_FXBMP_EN is defined.
package pcfx_bkram_pkg;

  localparam int SECT_WORDS   = 256;
  localparam int INT_SECT_DEF = 64;
  localparam int FXB_SECT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    NEXT
  } bk_state_t;

  typedef struct packed {
    logic       mnt;
    logic       ro;
    logic [8:0] nsect;
    logic       ld_pend;
    logic       sv_pend;
  } bk_slot_t;

  // Whole sectors in the image, limited to the RAM capacity.
  function automatic logic [8:0] clamp_sect(
    input logic [63:0] size,
    input int          cap
  );
    logic [54:0] s;
    s = size[63:9];
    if (s > 55'(cap)) return 9'(cap);
    return s[8:0];
  endfunction

endpackage

// File: rtl/pcfx_bkram_slot.sv
// One backup-RAM slot: mount capture, sector clamp and pending flags.
// Instantiated per RAM; slot 1 exists only with PCFX_FXBMP_EN.
module pcfx_bkram_slot
  import pcfx_bkram_pkg::*;
#(
  parameter int CAP = INT_SECT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        i_mount,
  input  logic        i_readonly,
  input  logic [63:0] i_size,
  input  logic        i_load,
  input  logic        i_save,
  input  logic        i_clr_ld,
  input  logic        i_clr_sv,
  output bk_slot_t    o_slot
);

  bk_slot_t r_slot;
  logic     w_nz;
  logic     w_unmnt;
  logic     w_ld_set;
  logic     w_sv_set;

  assign w_nz    = |i_size;
  assign w_unmnt = i_mount & ~w_nz;

  assign w_ld_set = i_mount ? w_nz
                  : (i_load & r_slot.mnt);
  assign w_sv_set = ~i_mount & i_save
                  & r_slot.mnt & ~r_slot.ro;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else begin
      if (i_mount) begin
        r_slot.mnt   <= w_nz;
        r_slot.ro    <= i_readonly;
        r_slot.nsect <= clamp_sect(i_size, CAP);
      end
      // An unmount drops anything still queued.
      r_slot.ld_pend <= w_ld_set
        | (r_slot.ld_pend & ~i_clr_ld & ~w_unmnt);
      r_slot.sv_pend <= w_sv_set
        | (r_slot.sv_pend & ~i_clr_sv & ~w_unmnt);
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/pcfx_bkram_sd.sv
// PC-FX backup-RAM <-> SD image streamer (load/save by 512-byte sectors).
// Define PCFX_FXBMP_EN to enable the FX-BMP slot (slot 1).
module pcfx_bkram_sd
  import pcfx_bkram_pkg::*;
#(
  parameter int INT_SECT = INT_SECT_DEF,
  parameter int FXB_SECT = FXB_SECT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic [1:0]  sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  output logic [15:0] sd_buff_din,
  input  logic        sd_buff_wr,
  output logic        ram_sel,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic        bk_ena,
  output logic        busy
);

  logic      r_load_d;
  logic      r_save_d;
  logic      w_load_re;
  logic      w_save_re;

  bk_slot_t  w_s0;
  bk_slot_t  w_s1;
  logic [1:0] w_clr_ld;
  logic [1:0] w_clr_sv;

  bk_state_t r_state;
  bk_state_t w_state_nx;
  logic      r_slot;
  logic      r_dir;
  logic [7:0] r_sect;
  logic [8:0] r_nsect;
  logic [1:0] r_rd;
  logic [1:0] r_wr;
  logic      r_we;
  logic [15:0] r_waddr;
  logic [15:0] r_wdata;

  logic      w_go;
  logic      w_start;
  logic      w_slot_nx;
  logic      w_dir_nx;
  logic [8:0] w_ns_nx;
  logic      w_ack;
  logic      w_we;
  logic      w_last;

  assign w_load_re = bk_load & ~r_load_d;
  assign w_save_re = bk_save & ~r_save_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_load_d <= 1'b0;
      r_save_d <= 1'b0;
    end else begin
      r_load_d <= bk_load;
      r_save_d <= bk_save;
    end
  end

  pcfx_bkram_slot #(
    .CAP (INT_SECT)
  ) u_slot0 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_mount    (img_mounted[0]),
    .i_readonly (img_readonly),
    .i_size     (img_size),
    .i_load     (w_load_re),
    .i_save     (w_save_re),
    .i_clr_ld   (w_clr_ld[0]),
    .i_clr_sv   (w_clr_sv[0]),
    .o_slot     (w_s0)
  );

`ifdef PCFX_FXBMP_EN
  pcfx_bkram_slot #(
    .CAP (FXB_SECT)
  ) u_slot1 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_mount    (img_mounted[1]),
    .i_readonly (img_readonly),
    .i_size     (img_size),
    .i_load     (w_load_re),
    .i_save     (w_save_re),
    .i_clr_ld   (w_clr_ld[1]),
    .i_clr_sv   (w_clr_sv[1]),
    .o_slot     (w_s1)
  );
`else
  assign w_s1 = '0;
`endif

  assign w_ack  = sd_ack[r_slot];
  assign w_last = ({1'b0, r_sect} + 9'd1) == r_nsect;

  // Loads first, then saves; slot 0 wins within each.
  always_comb begin
    w_state_nx = r_state;
    w_clr_ld   = '0;
    w_clr_sv   = '0;
    w_go       = 1'b0;
    w_start    = 1'b0;
    w_slot_nx  = r_slot;
    w_dir_nx   = r_dir;
    w_ns_nx    = r_nsect;
    unique case (r_state)
      IDLE: begin
        if (w_s0.ld_pend) begin
          w_go        = 1'b1;
          w_clr_ld[0] = 1'b1;
          w_slot_nx   = 1'b0;
          w_dir_nx    = 1'b0;
          w_ns_nx     = w_s0.nsect;
        end else if (w_s1.ld_pend) begin
          w_go        = 1'b1;
          w_clr_ld[1] = 1'b1;
          w_slot_nx   = 1'b1;
          w_dir_nx    = 1'b0;
          w_ns_nx     = w_s1.nsect;
        end else if (w_s0.sv_pend) begin
          w_go        = 1'b1;
          w_clr_sv[0] = 1'b1;
          w_slot_nx   = 1'b0;
          w_dir_nx    = 1'b1;
          w_ns_nx     = w_s0.nsect;
        end else if (w_s1.sv_pend) begin
          w_go        = 1'b1;
          w_clr_sv[1] = 1'b1;
          w_slot_nx   = 1'b1;
          w_dir_nx    = 1'b1;
          w_ns_nx     = w_s1.nsect;
        end
        // An empty image only consumes its flag.
        if (w_go && (w_ns_nx != '0)) begin
          w_start    = 1'b1;
          w_state_nx = REQ;
        end
      end
      REQ:  if (w_ack)  w_state_nx = XFER;
      XFER: if (!w_ack) w_state_nx = NEXT;
      NEXT: w_state_nx = w_last ? IDLE : REQ;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_we = sd_buff_wr & w_ack & ~r_dir
              & ((r_state == REQ) | (r_state == XFER));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_slot  <= 1'b0;
      r_dir   <= 1'b0;
      r_sect  <= '0;
      r_nsect <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) begin
        r_slot  <= w_slot_nx;
        r_dir   <= w_dir_nx;
        r_nsect <= w_ns_nx;
        r_sect  <= '0;
      end else if (r_state == NEXT && !w_last) begin
        r_sect <= r_sect + 8'd1;
      end
      r_rd <= '0;
      r_wr <= '0;
      if (r_state == REQ && !w_ack) begin
        if (r_dir) r_wr[r_slot] <= 1'b1;
        else       r_rd[r_slot] <= 1'b1;
      end
      r_we <= w_we;
      if (w_we) begin
        r_waddr <= {r_sect, sd_buff_addr};
        r_wdata <= sd_buff_dout;
      end
    end
  end

  assign sd_lba      = {24'd0, r_sect};
  assign busy        = r_state != IDLE;
  assign bk_ena      = w_s0.mnt;
  assign ram_we      = r_we;
  assign ram_wdata   = r_wdata;
  assign sd_buff_din = ram_rdata;
  // Saves read RAM directly; hps_io absorbs the 1-cycle latency.
  assign ram_addr    = r_dir ? {r_sect, sd_buff_addr}
                             : r_waddr;

`ifdef PCFX_FXBMP_EN
  assign sd_rd   = r_rd;
  assign sd_wr   = r_wr;
  assign ram_sel = r_slot;
`else
  localparam logic [8:0] LP_FXB = 9'(FXB_SECT);
  logic w_unused;
  assign sd_rd    = {1'b0, r_rd[0]};
  assign sd_wr    = {1'b0, r_wr[0]};
  assign ram_sel  = 1'b0;
  assign w_unused = &{1'b0, img_mounted[1],
                      r_rd[1], r_wr[1], LP_FXB};
`endif

endmodule
